// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand forwarding muxes,
// load-use hazard bubble insertion, flush/hold handling and a saturating
// hazard-stall counter.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_valid, id_is_load, id_use       ID instruction qualifiers / operand-use mask
//   id_ctrl                            ID control word (opaque)
//   id_op1_rf, id_op2_rf, id_r0_rf     register-file read values
//   op1_fwd, op2_fwd, r0_fwd           forwarding selects (00 RF, 01 EX, 10 M, 11 WB)
//   ex/m/wb_result, ex/m/wb_r0_result  result buses for forwarding
//   ext_stall, flush                   downstream hold / discard ID instruction
//   ex_valid, ex_is_load, ex_op1, ex_op2, ex_r0, ex_ctrl  registered EX-stage state
//   stall_out                          combinational hold request to PC and IF/ID
//   stall_count                        saturating count of hazard bubbles
module id_ex_operand_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_is_load,
    input  logic [2:0]        id_use,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_op1_rf,
    input  logic [DATA_W-1:0] id_op2_rf,
    input  logic [DATA_W-1:0] id_r0_rf,
    input  logic [1:0]        op1_fwd,
    input  logic [1:0]        op2_fwd,
    input  logic [1:0]        r0_fwd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] m_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [DATA_W-1:0] ex_r0_result,
    input  logic [DATA_W-1:0] m_r0_result,
    input  logic [DATA_W-1:0] wb_r0_result,
    input  logic              ext_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_is_load,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_r0,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              stall_out,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] FWD_EX = 2'b01;

    logic              valid_q,   valid_d;
    logic              is_load_q, is_load_d;
    logic [DATA_W-1:0] op1_q,     op1_d;
    logic [DATA_W-1:0] op2_q,     op2_d;
    logic [DATA_W-1:0] r0_q,      r0_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic [DATA_W-1:0] op1_mux_c;
    logic [DATA_W-1:0] op2_mux_c;
    logic [DATA_W-1:0] r0_mux_c;
    logic              hazard_c;

    // Four-way forwarding select: 00 RF, 01 EX, 10 M, 11 WB
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] ex,
        input logic [DATA_W-1:0] m,
        input logic [DATA_W-1:0] wb
    );
        logic [DATA_W-1:0] res;
        unique case (sel)
            2'b00:   res = rf;
            2'b01:   res = ex;
            2'b10:   res = m;
            default: res = wb;
        endcase
        return res;
    endfunction

    // Operand source selection
    always_comb begin
        op1_mux_c = fwd_sel(op1_fwd, id_op1_rf, ex_result, m_result, wb_result);
        op2_mux_c = fwd_sel(op2_fwd, id_op2_rf, ex_result, m_result, wb_result);
        r0_mux_c  = fwd_sel(r0_fwd, id_r0_rf, ex_r0_result, m_r0_result, wb_r0_result);
    end

    // Load-use hazard: a used operand wants the EX bus while EX holds a load,
    // whose data only exists from M onward
    always_comb begin
        hazard_c = id_valid & valid_q & is_load_q &
                   ((id_use[0] & (op1_fwd == FWD_EX)) |
                    (id_use[1] & (op2_fwd == FWD_EX)) |
                    (id_use[2] & (r0_fwd  == FWD_EX)));
    end

    assign stall_out = ext_stall | (hazard_c & ~flush);

    // Next-state: hold > flush > hazard bubble > normal load
    always_comb begin
        valid_d   = valid_q;
        is_load_d = is_load_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        r0_d      = r0_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        if (!ext_stall) begin
            if (flush || hazard_c) begin
                valid_d   = 1'b0;
                is_load_d = 1'b0;
                op1_d     = '0;
                op2_d     = '0;
                r0_d      = '0;
                ctrl_d    = '0;
                if (!flush && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d   = id_valid;
                is_load_d = id_valid & id_is_load;
                op1_d     = op1_mux_c;
                op2_d     = op2_mux_c;
                r0_d      = r0_mux_c;
                ctrl_d    = id_ctrl;
            end
        end
    end

    // EX-stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            is_load_q <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            r0_q      <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            is_load_q <= is_load_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            r0_q      <= r0_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_is_load  = is_load_q;
    assign ex_op1      = op1_q;
    assign ex_op2      = op2_q;
    assign ex_r0       = r0_q;
    assign ex_ctrl     = ctrl_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage (CNT_W=4 to reach saturation quickly).
module tb_id_ex_operand_stage;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CTRL_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              id_valid, id_is_load;
    logic [2:0]        id_use;
    logic [CTRL_W-1:0] id_ctrl;
    logic [DATA_W-1:0] id_op1_rf, id_op2_rf, id_r0_rf;
    logic [1:0]        op1_fwd, op2_fwd, r0_fwd;
    logic [DATA_W-1:0] ex_result, m_result, wb_result;
    logic [DATA_W-1:0] ex_r0_result, m_r0_result, wb_r0_result;
    logic              ext_stall, flush;
    logic              ex_valid, ex_is_load;
    logic [DATA_W-1:0] ex_op1, ex_op2, ex_r0;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              stall_out;
    logic [CNT_W-1:0]  stall_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    id_ex_operand_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_is_load(id_is_load), .id_use(id_use), .id_ctrl(id_ctrl),
        .id_op1_rf(id_op1_rf), .id_op2_rf(id_op2_rf), .id_r0_rf(id_r0_rf),
        .op1_fwd(op1_fwd), .op2_fwd(op2_fwd), .r0_fwd(r0_fwd),
        .ex_result(ex_result), .m_result(m_result), .wb_result(wb_result),
        .ex_r0_result(ex_r0_result), .m_r0_result(m_r0_result), .wb_r0_result(wb_r0_result),
        .ext_stall(ext_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_r0(ex_r0), .ex_ctrl(ex_ctrl),
        .stall_out(stall_out), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every input to a quiet value with distinct bus contents
    task automatic clear_inputs();
        id_valid = 0; id_is_load = 0; id_use = 3'b000; id_ctrl = 8'h00;
        id_op1_rf = 16'h1111; id_op2_rf = 16'h2222; id_r0_rf = 16'h3333;
        op1_fwd = 2'b00; op2_fwd = 2'b00; r0_fwd = 2'b00;
        ex_result = 16'hE1E1; m_result = 16'hA1A1; wb_result = 16'hB1B1;
        ex_r0_result = 16'hE0E0; m_r0_result = 16'hA0A0; wb_r0_result = 16'hB0B0;
        ext_stall = 0; flush = 0;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put a valid load into EX via a normal cycle
    task automatic load_into_ex();
        clear_inputs();
        id_valid = 1; id_is_load = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #12;
        n_cmp++; if (ex_valid !== 1'b0)    begin n_err++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        n_cmp++; if (ex_is_load !== 1'b0)  begin n_err++; $display("FAIL reset_is_load: got %b want 0", ex_is_load); end
        n_cmp++; if ({ex_op1, ex_op2, ex_r0} !== 48'h0) begin n_err++; $display("FAIL reset_ops: got %h want 0", {ex_op1, ex_op2, ex_r0}); end
        n_cmp++; if (ex_ctrl !== 8'h00)    begin n_err++; $display("FAIL reset_ctrl: got %h want 00", ex_ctrl); end
        n_cmp++; if (stall_count !== 4'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", stall_count); end
        n_cmp++; if (stall_out !== 1'b0)   begin n_err++; $display("FAIL reset_stall0: got %b want 0", stall_out); end
        ext_stall = 1; #1;
        n_cmp++; if (stall_out !== 1'b1)   begin n_err++; $display("FAIL reset_stall1: got %b want 1", stall_out); end
        ext_stall = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    task automatic test_plain_forward();
        clear_inputs();
        id_valid = 1; id_ctrl = 8'h5A; id_use = 3'b111;
        op1_fwd = 2'b01; ex_result = 16'h1234;
        op2_fwd = 2'b11; wb_result = 16'h00AB;
        r0_fwd  = 2'b10; m_r0_result = 16'hC0DE;
        #1;
        n_cmp++; if (stall_out !== 1'b0)  begin n_err++; $display("FAIL fwd_stall: got %b want 0", stall_out); end
        tick();
        n_cmp++; if (ex_op1 !== 16'h1234) begin n_err++; $display("FAIL fwd_op1: got %h want 1234", ex_op1); end
        n_cmp++; if (ex_op2 !== 16'h00AB) begin n_err++; $display("FAIL fwd_op2: got %h want 00ab", ex_op2); end
        n_cmp++; if (ex_r0 !== 16'hC0DE)  begin n_err++; $display("FAIL fwd_r0: got %h want c0de", ex_r0); end
        n_cmp++; if (ex_ctrl !== 8'h5A)   begin n_err++; $display("FAIL fwd_ctrl: got %h want 5a", ex_ctrl); end
        n_cmp++; if (ex_valid !== 1'b1)   begin n_err++; $display("FAIL fwd_valid: got %b want 1", ex_valid); end
        n_cmp++; if (ex_is_load !== 1'b0) begin n_err++; $display("FAIL fwd_is_load: got %b want 0", ex_is_load); end
    endtask

    task automatic test_rf_select();
        clear_inputs();
        id_valid = 1; id_is_load = 1; id_ctrl = 8'hC3;
        op1_fwd = 2'b00; op2_fwd = 2'b10; r0_fwd = 2'b11;
        tick();
        n_cmp++; if (ex_op1 !== 16'h1111) begin n_err++; $display("FAIL rf_op1: got %h want 1111", ex_op1); end
        n_cmp++; if (ex_op2 !== 16'hA1A1) begin n_err++; $display("FAIL rf_op2_m: got %h want a1a1", ex_op2); end
        n_cmp++; if (ex_r0 !== 16'hB0B0)  begin n_err++; $display("FAIL rf_r0_wb: got %h want b0b0", ex_r0); end
        n_cmp++; if (ex_is_load !== 1'b1) begin n_err++; $display("FAIL rf_is_load: got %b want 1", ex_is_load); end
        // R0 select 00 and 01 too
        clear_inputs();
        id_valid = 1; r0_fwd = 2'b01;
        tick();
        n_cmp++; if (ex_r0 !== 16'hE0E0)  begin n_err++; $display("FAIL r0_ex: got %h want e0e0", ex_r0); end
        clear_inputs();
        id_valid = 1; r0_fwd = 2'b00; op2_fwd = 2'b01;
        tick();
        n_cmp++; if (ex_r0 !== 16'h3333)  begin n_err++; $display("FAIL r0_rf: got %h want 3333", ex_r0); end
        n_cmp++; if (ex_op2 !== 16'hE1E1) begin n_err++; $display("FAIL op2_ex: got %h want e1e1", ex_op2); end
    endtask

    task automatic test_load_use();
        load_into_ex();
        clear_inputs();
        id_valid = 1; id_use = 3'b001; op1_fwd = 2'b01; id_ctrl = 8'h77;
        #1;
        n_cmp++; if (stall_out !== 1'b1)  begin n_err++; $display("FAIL lu_stall: got %b want 1", stall_out); end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (ex_valid !== 1'b0)   begin n_err++; $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); end
        n_cmp++; if ({ex_op1, ex_ctrl} !== 24'h0) begin n_err++; $display("FAIL lu_bubble_data: got %h want 0", {ex_op1, ex_ctrl}); end
        n_cmp++; if (stall_count !== exp_cnt) begin n_err++; $display("FAIL lu_cnt: got %h want %h", stall_count, exp_cnt); end
        // Retry: forwarding unit now points at M
        op1_fwd = 2'b10; m_result = 16'hBEEF;
        #1;
        n_cmp++; if (stall_out !== 1'b0)  begin n_err++; $display("FAIL lu_retry_stall: got %b want 0", stall_out); end
        tick();
        n_cmp++; if (ex_op1 !== 16'hBEEF) begin n_err++; $display("FAIL lu_retry_op1: got %h want beef", ex_op1); end
        n_cmp++; if (ex_valid !== 1'b1)   begin n_err++; $display("FAIL lu_retry_valid: got %b want 1", ex_valid); end
        n_cmp++; if (stall_count !== exp_cnt) begin n_err++; $display("FAIL lu_retry_cnt: got %h want %h", stall_count, exp_cnt); end
    endtask

    task automatic test_unused_operand();
        load_into_ex();
        clear_inputs();
        id_valid = 1; id_use = 3'b010; op1_fwd = 2'b01;
        #1;
        n_cmp++; if (stall_out !== 1'b0)  begin n_err++; $display("FAIL unused_stall: got %b want 0", stall_out); end
        tick();
        n_cmp++; if (ex_valid !== 1'b1)   begin n_err++; $display("FAIL unused_valid: got %b want 1", ex_valid); end
        n_cmp++; if (stall_count !== exp_cnt) begin n_err++; $display("FAIL unused_cnt: got %h want %h", stall_count, exp_cnt); end
    endtask

    task automatic test_r0_hazard();
        load_into_ex();
        clear_inputs();
        id_valid = 1; id_use = 3'b100; r0_fwd = 2'b01;
        #1;
        n_cmp++; if (stall_out !== 1'b1)  begin n_err++; $display("FAIL r0hz_stall: got %b want 1", stall_out); end
        tick();
        exp_cnt = exp_cnt + 4'd1;
        n_cmp++; if (ex_valid !== 1'b0)   begin n_err++; $display("FAIL r0hz_valid: got %b want 0", ex_valid); end
        n_cmp++; if (stall_count !== exp_cnt) begin n_err++; $display("FAIL r0hz_cnt: got %h want %h", stall_count, exp_cnt); end
    endtask

    task automatic test_flush();
        load_into_ex();
        clear_inputs();
        id_valid = 1; id_use = 3'b011; op2_fwd = 2'b01; flush = 1; id_ctrl = 8'hFF;
        #1;
        n_cmp++; if (stall_out !== 1'b0)  begin n_err++; $display("FAIL flush_stall: got %b want 0", stall_out); end
        tick();
        n_cmp++; if ({ex_valid, ex_is_load} !== 2'b00) begin n_err++; $display("FAIL flush_valid: got %b want 00", {ex_valid, ex_is_load}); end
        n_cmp++; if ({ex_op2, ex_ctrl} !== 24'h0) begin n_err++; $display("FAIL flush_data: got %h want 0", {ex_op2, ex_ctrl}); end
        n_cmp++; if (stall_count !== exp_cnt) begin n_err++; $display("FAIL flush_cnt: got %h want %h", stall_count, exp_cnt); end
        // Flush of an ordinary instruction also bubbles
        clear_inputs();
        id_valid = 1; flush = 1; id_ctrl = 8'h12;
        tick();
        n_cmp++; if ({ex_valid, ex_ctrl} !== 9'h0) begin n_err++; $display("FAIL flush_plain: got %h want 0", {ex_valid, ex_ctrl}); end
    endtask

    task automatic test_hold();
        clear_inputs();
        id_valid = 1; id_is_load = 1; id_ctrl = 8'h3C; id_op1_rf = 16'h0101;
        op2_fwd = 2'b11; wb_result = 16'h0202; r0_fwd = 2'b10; m_r0_result = 16'h0303;
        tick();
        for (int i = 0; i < 3; i++) begin
            id_valid = i[0]; id_is_load = 0; id_ctrl = 8'h90 + 8'(i);
            id_op1_rf = 16'hF000 + 16'(i); wb_result = 16'hE000 + 16'(i);
            m_r0_result = 16'hD000 + 16'(i); flush = (i == 1);
            id_use = 3'b001; op1_fwd = 2'b01;  // would be a hazard without hold
            ext_stall = 1;
            #1;
            n_cmp++; if (stall_out !== 1'b1) begin n_err++; $display("FAIL hold_stall%0d: got %b want 1", i, stall_out); end
            tick();
            n_cmp++; if ({ex_valid, ex_is_load, ex_ctrl} !== {2'b11, 8'h3C}) begin n_err++; $display("FAIL hold_ctl%0d: got %h want 33c", i, {ex_valid, ex_is_load, ex_ctrl}); end
            n_cmp++; if ({ex_op1, ex_op2, ex_r0} !== 48'h0101_0202_0303) begin n_err++; $display("FAIL hold_ops%0d: got %h want 010102020303", i, {ex_op1, ex_op2, ex_r0}); end
            n_cmp++; if (stall_count !== exp_cnt) begin n_err++; $display("FAIL hold_cnt%0d: got %h want %h", i, stall_count, exp_cnt); end
        end
        clear_inputs();
        id_valid = 1; id_ctrl = 8'hA5; op1_fwd = 2'b11; wb_result = 16'h4242;
        tick();
        n_cmp++; if ({ex_valid, ex_ctrl, ex_op1} !== {1'b1, 8'hA5, 16'h4242}) begin n_err++; $display("FAIL hold_release: got %h want 1a54242", {ex_valid, ex_ctrl, ex_op1}); end
    endtask

    task automatic test_id_invalid();
        clear_inputs();
        id_valid = 0; id_is_load = 1; id_op1_rf = 16'h5555; id_ctrl = 8'h66;
        id_use = 3'b001; op1_fwd = 2'b00;
        tick();
        n_cmp++; if ({ex_valid, ex_is_load} !== 2'b00) begin n_err++; $display("FAIL inv_valid: got %b want 00", {ex_valid, ex_is_load}); end
        n_cmp++; if (ex_op1 !== 16'h5555) begin n_err++; $display("FAIL inv_op1: got %h want 5555", ex_op1); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 16; i++) begin
            load_into_ex();
            clear_inputs();
            id_valid = 1; id_use = 3'b001; op1_fwd = 2'b01;
            tick();
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            n_cmp++; if (stall_count !== exp_cnt) begin n_err++; $display("FAIL sat_cnt%0d: got %h want %h", i, stall_count, exp_cnt); end
        end
        n_cmp++; if (stall_count !== 4'hF) begin n_err++; $display("FAIL sat_final: got %h want f", stall_count); end
    endtask

    task automatic test_reset_mid();
        load_into_ex();
        clear_inputs();
        id_valid = 1; id_use = 3'b001; op1_fwd = 2'b01;
        #1;
        n_cmp++; if (stall_out !== 1'b1)  begin n_err++; $display("FAIL rstmid_pre_stall: got %b want 1", stall_out); end
        #1;
        rst_n = 0;
        #1;
        n_cmp++; if ({ex_valid, ex_is_load, ex_ctrl} !== 10'h0) begin n_err++; $display("FAIL rstmid_ctl: got %h want 0", {ex_valid, ex_is_load, ex_ctrl}); end
        n_cmp++; if ({ex_op1, ex_op2, ex_r0} !== 48'h0) begin n_err++; $display("FAIL rstmid_ops: got %h want 0", {ex_op1, ex_op2, ex_r0}); end
        n_cmp++; if (stall_count !== 4'h0) begin n_err++; $display("FAIL rstmid_cnt: got %h want 0", stall_count); end
        n_cmp++; if (stall_out !== 1'b0)  begin n_err++; $display("FAIL rstmid_stall: got %b want 0", stall_out); end
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        id_valid = 1; id_ctrl = 8'h81; op1_fwd = 2'b01; ex_result = 16'h9876;
        #1;
        n_cmp++; if (ex_valid !== 1'b0)   begin n_err++; $display("FAIL rstmid_post_valid: got %b want 0", ex_valid); end
        tick();
        n_cmp++; if ({ex_valid, ex_ctrl, ex_op1} !== {1'b1, 8'h81, 16'h9876}) begin n_err++; $display("FAIL rstmid_resume: got %h want 1819876", {ex_valid, ex_ctrl, ex_op1}); end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_plain_forward();
        test_rf_select();
        test_load_use();
        test_unused_operand();
        test_r0_hazard();
        test_flush();
        test_hold();
        test_id_invalid();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
